pdp8lvcring: RTL and testbench

Parametrised point-display ring buffer, successor to the fixed VC-8 ring. It accepts plotted points from the IOP decoder over a valid/ready handshake and stores {intensity, y, x} words in a dual-port video RAM ring. The ARM drains the ring through a register window. New in this generation: parametrised widths and depth, overwrite-oldest or drop-newest on full, duplicate-point suppression, a saturating overflow counter and a fill-threshold interrupt.

---
 rtl/pdp8lvcring.sv | 173 +++++++++++++++++
 tb/tb_pdp8lvcring.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pdp8lvcring.sv
// Point-display ring buffer: IOP points go into a dual-port video RAM ring,
// and the ARM drains the ring through an eight-register window.
module pdp8lvcring #(
   parameter int XYW = 10,
   parameter int IW  = 2,
   parameter int AW  = 15,
   localparam int DW = IW + 2*XYW
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   input  logic          BINIT,
   input  logic          armwrite,
   input  logic [2:0]    armraddr,
   input  logic [2:0]    armwaddr,
   input  logic [31:0]   armwdata,
   output logic [31:0]   armrdata,
   input  logic          ptvalid,
   output logic          ptready,
   input  logic [XYW-1:0] ptx,
   input  logic [XYW-1:0] pty,
   input  logic [IW-1:0] ptint,
   output logic          INT_RQST,
   output logic [AW-1:0] vidaddra,
   output logic [DW-1:0] viddataa,
   output logic          videnaba,
   output logic          vidwrena,
   output logic [AW-1:0] vidaddrb,
   output logic          videnabb,
   input  logic [DW-1:0] viddatab
);

   typedef enum logic [1:0] {W_IDLE, W_WR, W_DONE} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_CAPT} rstate_t;

   wstate_t wst, wst_nx;
   rstate_t rst, rst_nx;

   logic [AW-1:0] insert, remove, thresh, count;
   logic          ovw, dedup, ie;
   logic [11:0]   ovfcnt;
   logic          last_vld, wr_full, rempty;
   logic [DW-1:0] last_word, rdata, point;
   logic          empty, full, accept, dup, take, drop, w_push, ovwpush;
   logic          rbusy, rd_start, pop, pop_empty, ptr_ld, ovf_clr;
   logic          unused_wdata;

   assign unused_wdata = ^armwdata;
   assign point     = {ptint, pty, ptx};
   assign count     = insert - remove;
   assign empty     = (count == '0);
   assign full      = &count;
   assign ptready   = (wst == W_IDLE) & ~BINIT;
   assign accept    = ptvalid & ptready;
   assign dup       = dedup & last_vld & (point == last_word);
   assign drop      = accept & ~dup & full & ~ovw;
   assign take      = accept & ~dup & ~(full & ~ovw);
   // Pointers move on the edge leaving W_WR so insert is visible two cycles after accept.
   assign w_push    = (wst == W_WR);
   assign ovwpush   = w_push & wr_full;
   assign rbusy     = (rst != R_IDLE);
   assign rd_start  = armwrite & (armwaddr == 3'd4) & ~rbusy;
   assign pop       = rd_start & armwdata[31] & ~empty;
   assign pop_empty = rd_start & armwdata[31] & empty;
   assign ptr_ld    = armwrite & (armwaddr == 3'd1);
   assign ovf_clr   = armwrite & (armwaddr == 3'd3) & armwdata[31];
   assign INT_RQST  = ie & (thresh != '0) & (count >= thresh);

   always_comb begin
      wst_nx = wst;
      case (wst)
         W_IDLE:  if (take) wst_nx = W_WR;
         W_WR:    wst_nx = W_DONE;
         W_DONE:  wst_nx = W_IDLE;
         default: wst_nx = W_IDLE;
      endcase
   end

   always_comb begin
      rst_nx = rst;
      case (rst)
         R_IDLE:  if (rd_start && !pop_empty) rst_nx = R_ADDR;
         R_ADDR:  rst_nx = R_WAIT;
         R_WAIT:  rst_nx = R_CAPT;
         default: rst_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         ovw <= 1'b0; dedup <= 1'b0; ie <= 1'b0; thresh <= '0;
      end else if (armwrite && armwaddr == 3'd2) begin
         ovw    <= armwdata[31];
         dedup  <= armwdata[30];
         ie     <= armwdata[29];
         thresh <= armwdata[AW-1:0];
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         wst <= W_IDLE; rst <= R_IDLE;
         insert <= '0; remove <= '0; ovfcnt <= '0;
         last_vld <= 1'b0; last_word <= '0; wr_full <= 1'b0;
         vidaddra <= '0; viddataa <= '0; videnaba <= 1'b0; vidwrena <= 1'b0;
         vidaddrb <= '0; videnabb <= 1'b0; rdata <= '0; rempty <= 1'b0;
      end else if (BINIT) begin
         wst <= W_IDLE; rst <= R_IDLE;
         insert <= '0; remove <= '0; ovfcnt <= '0; last_vld <= 1'b0;
         videnaba <= 1'b0; vidwrena <= 1'b0; videnabb <= 1'b0;
      end else begin
         wst <= wst_nx;
         rst <= rst_nx;
         videnaba <= take;
         vidwrena <= take;
         if (take) begin
            vidaddra  <= insert;
            viddataa  <= point;
            wr_full   <= full;
            last_word <= point;
            last_vld  <= 1'b1;
         end
         // A pointer load overrides every other pointer update in the same cycle.
         if (ptr_ld) begin
            insert   <= armwdata[AW-1:0];
            remove   <= armwdata[16 +: AW];
            last_vld <= 1'b0;
         end else begin
            if (w_push) insert <= insert + 1'b1;
            remove <= remove + AW'(pop) + AW'(ovwpush);
         end
         if (ovf_clr)
            ovfcnt <= '0;
         else if ((drop || ovwpush) && ovfcnt != 12'hFFF)
            ovfcnt <= ovfcnt + 1'b1;
         if (pop_empty) rempty <= 1'b1;
         if (rst == R_IDLE && rd_start && !pop_empty) begin
            rempty   <= 1'b0;
            vidaddrb <= armwdata[31] ? remove : armwdata[AW-1:0];
            videnabb <= 1'b1;
         end
         if (rst == R_CAPT) begin
            rdata    <= viddatab;
            videnabb <= 1'b0;
         end
      end
   end

   always_comb begin
      armrdata = '0;
      case (armraddr)
         3'd0: armrdata = 32'h5652_2001;
         3'd1: begin
            armrdata[16 +: AW] = remove;
            armrdata[AW-1:0]   = insert;
         end
         3'd2: begin
            armrdata[31] = ovw; armrdata[30] = dedup; armrdata[29] = ie;
            armrdata[AW-1:0] = thresh;
         end
         3'd3: begin
            armrdata[31] = empty; armrdata[30] = full; armrdata[29] = INT_RQST;
            armrdata[27:16]  = ovfcnt;
            armrdata[AW-1:0] = count;
         end
         3'd4: begin
            armrdata[31] = rbusy; armrdata[30] = rempty;
            armrdata[DW-1:0] = rdata;
         end
         default: armrdata = 32'hDEAD_BEEF;
      endcase
   end

endmodule

// File: tb/tb_pdp8lvcring.sv
// Directed bench for pdp8lvcring with an 8-entry ring and a behavioural dual-port RAM.
module tb_pdp8lvcring;
   logic        CLOCK = 1'b0, RESET_N = 1'b0, BINIT = 1'b0;
   logic        armwrite = 1'b0;
   logic [2:0]  armraddr = '0, armwaddr = '0;
   logic [31:0] armwdata = '0, armrdata;
   logic        ptvalid = 1'b0, ptready, INT_RQST;
   logic [9:0]  ptx = '0, pty = '0;
   logic [1:0]  ptint = '0;
   logic [2:0]  vidaddra, vidaddrb;
   logic [21:0] viddataa, viddatab;
   logic        videnaba, vidwrena, videnabb;

   int n_chk = 0, n_fail = 0, nwr = 0, n0;
   logic [21:0] mem [8];

   pdp8lvcring #(.XYW(10), .IW(2), .AW(3)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .BINIT(BINIT),
      .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
      .armwdata(armwdata), .armrdata(armrdata),
      .ptvalid(ptvalid), .ptready(ptready), .ptx(ptx), .pty(pty), .ptint(ptint),
      .INT_RQST(INT_RQST),
      .vidaddra(vidaddra), .viddataa(viddataa), .videnaba(videnaba), .vidwrena(vidwrena),
      .vidaddrb(vidaddrb), .videnabb(videnabb), .viddatab(viddatab));

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) begin
      if (videnaba && vidwrena) begin
         mem[vidaddra] <= viddataa;
         nwr <= nwr + 1;
      end
      if (videnabb) viddatab <= mem[vidaddrb];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick; @(posedge CLOCK); #1; endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
      armraddr = a; #1;
      chk(tag, armrdata, exp);
   endtask

   task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
      armwaddr = a; armwdata = d; armwrite = 1'b1;
      tick;
      armwrite = 1'b0;
   endtask

   function automatic logic [31:0] w(input int x, input int y, input int i);
      return {10'b0, i[1:0], y[9:0], x[9:0]};
   endfunction

   task automatic push(input int x, input int y, input int i);
      int n = 0;
      ptx = x[9:0]; pty = y[9:0]; ptint = i[1:0]; ptvalid = 1'b1;
      while (!ptready && n < 20) begin tick; n++; end
      chk("push_ready", ptready, 1);
      tick;
      ptvalid = 1'b0;
      tick; tick;
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      arm_wr(3'd4, 32'h8000_0000);
      tick; tick; tick;
      chk_reg(tag, 3'd4, exp);
   endtask

   initial begin
      // reset state
      tick; tick;
      chk("rst_enaba", videnaba, 0);
      chk("rst_wrena", vidwrena, 0);
      chk("rst_enabb", videnabb, 0);
      chk("rst_addra", vidaddra, 0);
      chk("rst_dataa", viddataa, 0);
      chk("rst_addrb", vidaddrb, 0);
      chk("rst_int", INT_RQST, 0);
      RESET_N = 1'b1;
      tick;
      chk("rst_ptready", ptready, 1);
      chk_reg("reg0_id", 3'd0, 32'h5652_2001);
      chk_reg("rst_status", 3'd3, 32'h8000_0000);
      chk_reg("rst_ctl", 3'd2, 32'h0);
      chk_reg("rst_rdport", 3'd4, 32'h0);
      chk_reg("reg5", 3'd5, 32'hDEAD_BEEF);
      chk_reg("reg7", 3'd7, 32'hDEAD_BEEF);

      // first point: enables one cycle after accept, for exactly one cycle
      ptx = 10'd5; pty = 10'd7; ptint = 2'd3; ptvalid = 1'b1;
      tick;
      ptvalid = 1'b0;
      chk("p1_enaba", videnaba, 1);
      chk("p1_wrena", vidwrena, 1);
      chk("p1_addr", vidaddra, 0);
      chk("p1_data", viddataa, 32'h0030_1C05);
      tick;
      chk("p1_enaba_off", videnaba, 0);
      tick;
      chk_reg("p1_status", 3'd3, 32'h0000_0001);
      chk_reg("p1_ptrs", 3'd1, 32'h0000_0001);
      pop_chk("p1_pop", w(5, 7, 3));

      // duplicate suppression, and re-arm via a pointer load
      arm_wr(3'd2, 32'h4000_0000);
      n0 = nwr;
      push(1, 2, 1);
      push(1, 2, 1);
      chk("dedup_writes", nwr - n0, 1);
      chk_reg("dedup_status", 3'd3, 32'h0000_0001);
      arm_wr(3'd1, 32'h0);
      push(1, 2, 1);
      chk("dedup_rewrite", nwr - n0, 2);
      chk_reg("dedup_status2", 3'd3, 32'h0000_0001);
      arm_wr(3'd2, 32'h0);

      // drop-newest on full
      arm_wr(3'd1, 32'h0);
      arm_wr(3'd3, 32'h8000_0000);
      for (int k = 1; k <= 9; k++) push(k, 100 + k, 1);
      chk_reg("drop_status", 3'd3, 32'h4002_0007);
      for (int k = 1; k <= 7; k++) pop_chk("drop_pop", w(k, 100 + k, 1));
      arm_wr(3'd4, 32'h8000_0000);
      chk("empty_pop_enabb", videnabb, 0);
      tick;
      chk("empty_pop_enabb2", videnabb, 0);
      armraddr = 3'd4; #1;
      chk("empty_pop_rempty", armrdata[31:30], 2'b01);

      // overwrite-oldest on full
      arm_wr(3'd2, 32'h8000_0000);
      arm_wr(3'd1, 32'h0);
      arm_wr(3'd3, 32'h8000_0000);
      for (int k = 1; k <= 9; k++) push(k, 100 + k, 1);
      chk_reg("ovw_status", 3'd3, 32'h4002_0007);
      chk_reg("ovw_ptrs", 3'd1, 32'h0002_0001);
      for (int k = 3; k <= 9; k++) pop_chk("ovw_pop", w(k, 100 + k, 1));
      chk_reg("ovw_drained", 3'd3, 32'h8002_0000);

      // fill-threshold interrupt
      arm_wr(3'd2, 32'h2000_0004);
      chk_reg("thr_ctl", 3'd2, 32'h2000_0004);
      for (int k = 1; k <= 3; k++) push(200 + k, 300 + k, 2);
      chk("thr_int_3", INT_RQST, 0);
      push(204, 304, 2);
      chk("thr_int_4", INT_RQST, 1);
      chk_reg("thr_status", 3'd3, 32'h2002_0004);
      pop_chk("thr_pop", w(201, 301, 2));
      chk("thr_int_pop", INT_RQST, 0);

      // random read at address 2 leaves pointers alone
      arm_wr(3'd4, 32'h0000_0002);
      chk("rnd_enabb", videnabb, 1);
      chk("rnd_addrb", vidaddrb, 2);
      tick; tick;
      armraddr = 3'd4; #1;
      chk("rnd_busy", armrdata[31], 1);
      tick;
      chk_reg("rnd_data", 3'd4, w(202, 302, 2));
      chk_reg("rnd_ptrs", 3'd1, 32'h0002_0005);

      // soft clear keeps ctl
      BINIT = 1'b1; #1;
      chk("binit_ptready", ptready, 0);
      tick;
      BINIT = 1'b0;
      chk_reg("binit_ptrs", 3'd1, 32'h0);
      chk_reg("binit_status", 3'd3, 32'h8000_0000);
      chk_reg("binit_ctl", 3'd2, 32'h2000_0004);

      // async reset in the middle of a write
      ptx = 10'd9; pty = 10'd9; ptint = 2'd1; ptvalid = 1'b1;
      tick;
      ptvalid = 1'b0;
      chk("mid_enaba", videnaba, 1);
      RESET_N = 1'b0; #1;
      chk("mid_rst_enaba", videnaba, 0);
      chk("mid_rst_wrena", vidwrena, 0);
      chk_reg("mid_rst_ctl", 3'd2, 32'h0);
      tick;
      RESET_N = 1'b1;
      tick;
      chk("mid_rst_ptready", ptready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
